// File: rtl/button_conditioner.sv
// button_conditioner: per-button synchroniser, debouncer and press/release/long-press pulse generator.
// Define BUTTON_AUTOREPEAT_EN to re-pulse btn_press every REPEAT_CYCLES after a long press.
module button_conditioner #(
  parameter int NUM_BTNS        = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter bit ACTIVE_LOW_IN   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_long
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_SAT  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);

  logic [NUM_BTNS-1:0] meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= btn_raw ^ {NUM_BTNS{ACTIVE_LOW_IN}};
      sync_q <= meta_q;
    end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    logic          lvl_q, lvl_d, press_q, press_d, rel_q, rel_d, long_q, long_d;
    logic          chg, done, rep;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;

    // hcnt parks at HOLD_CYCLES once btn_long has fired, so it fires once per press
    always_comb begin
      chg     = sync_q[i] != lvl_q;
      done    = chg && dcnt_q == D_LAST;
      lvl_d   = lvl_q ^ done;
      dcnt_d  = (chg && !done) ? dcnt_q + DW'(1) : '0;
      hcnt_d  = !lvl_q ? '0 : (hcnt_q == H_SAT ? H_SAT : hcnt_q + HW'(1));
      long_d  = lvl_q && hcnt_q == H_LAST;
      press_d = (lvl_d && !lvl_q) || rep;
      rel_d   = lvl_q && !lvl_d;
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rcnt_q, rcnt_d;

    // repeats are suppressed on the edge the level drops, so press never meets release
    always_comb begin
      rep    = lvl_q && lvl_d && hcnt_q == H_SAT && rcnt_q == R_LAST;
      rcnt_d = (lvl_q && lvl_d && hcnt_q == H_SAT && !rep) ? rcnt_q + RW'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rcnt_q <= '0;
      else        rcnt_q <= rcnt_d;
`else
    logic unused_repeat;
    assign rep           = 1'b0;
    assign unused_repeat = ^REPEAT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        lvl_q   <= 1'b0;
        dcnt_q  <= '0;
        hcnt_q  <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        lvl_q   <= lvl_d;
        dcnt_q  <= dcnt_d;
        hcnt_q  <= hcnt_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
      end

    assign btn_level[i]   = lvl_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
    assign btn_long[i]    = long_q;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table vectors, directed corner sequences and random stimulus against a window-based reference model.
`timescale 1ns/1ps
module tb_button_conditioner;
  localparam int N = 3, D = 4, H = 10, R = 5;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] raw, lvl, press, rel, lng;
  } vec_t;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long;
  int           vectors = 0, errors = 0, cyc = 0;

  button_conditioner #(
    .NUM_BTNS(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .ACTIVE_LOW_IN(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long)
  );

  always #5 clk = ~clk;

  // reference: level flips when the last D synchronised samples all disagree with it
  bit           m_s1[N], m_s2[N], m_lvl[N];
  bit           win[N][D];
  int           filled[N], m_high[N];
  logic [N-1:0] e_lvl, e_press, e_rel, e_long;

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; filled[c] = 0; m_high[c] = 0;
      for (int j = 0; j < D; j++) win[c][j] = 0;
    end
    e_lvl = '0; e_press = '0; e_rel = '0; e_long = '0;
  endfunction

  function automatic void model_edge(logic [N-1:0] r);
    bit s, old, nw, diff;
    for (int c = 0; c < N; c++) begin
      s = m_s2[c]; m_s2[c] = m_s1[c]; m_s1[c] = r[c];
      old = m_lvl[c];
      for (int j = D - 1; j > 0; j--) win[c][j] = win[c][j-1];
      win[c][0] = s;
      if (filled[c] < D) filled[c]++;
      diff = filled[c] == D;
      for (int j = 0; j < D; j++) if (win[c][j] == old) diff = 0;
      nw = old ^ diff;
      m_high[c] = old ? m_high[c] + 1 : 0;
      e_long[c]  = old && m_high[c] == H;
      e_press[c] = (nw && !old) || (AR && old && nw && m_high[c] > H && (m_high[c] - H) % R == 0);
      e_rel[c]   = old && !nw;
      e_lvl[c]   = nw;
      m_lvl[c]   = nw;
    end
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare_model();
    check("level", btn_level, e_lvl);
    check("press", btn_press, e_press);
    check("release", btn_release, e_rel);
    check("long", btn_long, e_long);
  endtask

  task automatic tick();
    logic [N-1:0] r;
    r = btn_raw;
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(r);
    else model_reset();
    #1;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    errors++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[15];
    int   t_rise, t_long, n_long, n_press, t_rel, t_press;
    logic [N-1:0] pval;
    tbl[0]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[2]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[3]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[4]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[5]  = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
    tbl[6]  = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[7]  = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[8]  = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[9]  = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[10] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[11] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[12] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    tbl[13] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    tbl[14] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

    model_reset();
    idle(2);
    #2 rst_n = 1'b1;
    idle(3);

    for (int i = 0; i < 15; i++) begin
      btn_raw = tbl[i].raw;
      tick();
      check("tbl_level", btn_level, tbl[i].lvl);
      check("tbl_press", btn_press, tbl[i].press);
      check("tbl_release", btn_release, tbl[i].rel);
      check("tbl_long", btn_long, tbl[i].lng);
    end
    idle(3);

    // bounce: 3-high/1-low pattern never reaches D consecutive samples
    n_press = 0;
    for (int i = 0; i < 32; i++) begin
      btn_raw[1] = (i % 4) != 3;
      tick();
      n_press += int'(btn_level[1] | btn_press[1] | btn_release[1]);
    end
    check_int("bounce_quiet", n_press, 0);
    btn_raw[1] = 1'b1;
    n_press = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_press += int'(btn_press[1]);
    end
    check_int("bounce_accept_press", n_press, 1);
    check("bounce_level", btn_level, 3'b010);
    btn_raw[1] = 1'b0;
    idle(8);

    // long press on channel 2
    btn_raw[2] = 1'b1;
    t_rise = -1; t_long = -1; n_long = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (btn_press[2] && t_rise < 0) t_rise = i;
      if (btn_long[2]) begin n_long++; if (t_long < 0) t_long = i; end
    end
    check_int("long_rise_latency", t_rise, 5);
    check_int("long_after_rise", t_long - t_rise, 10);
    check_int("long_once", n_long, 1);
    btn_raw[2] = 1'b0;
    t_rel = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (btn_release[2] && t_rel < 0) t_rel = i;
    end
    check_int("release_latency", t_rel, 5);
    idle(2);

    // all channels together
    btn_raw = 3'b111;
    t_press = -1; pval = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (btn_press != '0 && t_press < 0) begin t_press = i; pval = btn_press; end
    end
    check_int("simul_latency", t_press, 5);
    check("simul_press", pval, 3'b111);
    btn_raw = '0;
    idle(8);

    // asynchronous reset while a press is being held
    btn_raw[0] = 1'b1;
    t_rise = -1;
    for (int i = 0; i < 10 && t_rise < 0; i++) begin
      tick();
      if (btn_level[0]) t_rise = i;
    end
    check_int("rst_pre_rise", t_rise, 5);
    idle(2);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_model();
    check("rst_async_level", btn_level, 3'b000);
    idle(2);
    rst_n = 1'b1;
    t_press = -1; t_long = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (btn_press[0] && t_press < 0) t_press = i;
      if (btn_long[0] && t_long < 0) t_long = i;
    end
    check_int("rst_repress_latency", t_press, 5);
    check_int("rst_long_fresh", t_long, 15);
    btn_raw[0] = 1'b0;
    idle(8);

    // 40-cycle hold: repeats at long+5, +10, ... only with the autorepeat build
    btn_raw[0] = 1'b1;
    n_press = 0; n_long = 0;
    for (int i = 0; i < 48; i++) begin
      if (i == 40) btn_raw[0] = 1'b0;
      tick();
      n_press += int'(btn_press[0]);
      n_long  += int'(btn_long[0]);
    end
    check_int("repeat_press_count", n_press, AR ? 6 : 1);
    check_int("repeat_long_count", n_long, 1);

    // random: fast flips exercise bouncing, slow flips reach long/repeat
    for (int i = 0; i < 900; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, (i < 300) ? 3 : 19) == 0) btn_raw[c] = ~btn_raw[c];
      if ($urandom_range(0, 149) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare_model();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised front end for all game push-buttons (reset, player1, player2, and future menu/serve buttons).
- Per channel, it:
  - synchronises the raw pad input,
  - debounces it with a consecutive-sample counter,
  - emits a clean level plus single-cycle press, release and long-press pulses.
- Sits between the board pins and the game FSM / paddle logic. Everything downstream sees only glitch-free, clock-aligned events.

Parameters:
- NUM_BTNS, 3: number of independent button channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a change (10 ms at 100 MHz); must be >= 1.
- HOLD_CYCLES, 50000000: cycles the debounced level must stay high before btn_long fires (0.5 s); must be >= 1.
- REPEAT_CYCLES, 10000000: auto-repeat period; used only when the optional feature is compiled in; must be >= 1.
- ACTIVE_LOW_IN, 0: when 1, btn_raw is inverted before synchronisation (pressed = pad low).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset, applied to every flop.
- btn_raw  input  NUM_BTNS  raw asynchronous pad inputs, one bit per button.
- btn_level  output  NUM_BTNS  debounced level, 1 = pressed.
- btn_press  output  NUM_BTNS  one-cycle pulse on an accepted press (and auto-repeat, if enabled).
- btn_release  output  NUM_BTNS  one-cycle pulse on an accepted release.
- btn_long  output  NUM_BTNS  one-cycle pulse when a press has been held HOLD_CYCLES cycles.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0;
  - synchroniser flops, stable state and all counters 0 (released state, after optional inversion).
  - Release of rst_n is not otherwise special.
- Channels are fully independent. Any combination may change or pulse in the same cycle.
- Synchroniser: two flops per channel, input = btn_raw XOR ACTIVE_LOW_IN. Call the second flop s.
- Debounce, per channel, with stable state q (drives btn_level) and counter dcnt, width $clog2(DEBOUNCE_CYCLES+1):
  - s == q: dcnt cleared to 0. Any single bounce sample restarts the count.
  - s != q and dcnt == DEBOUNCE_CYCLES-1: q toggles, dcnt cleared.
  - s != q otherwise: dcnt increments.
- Latency: a raw change sampled at edge k (first sync flop) and held clean appears on btn_level after edge k+1+DEBOUNCE_CYCLES.
- Edge pulses, registered: btn_press/btn_release are high for exactly the cycle in which btn_level first shows 1/0.
- Press and release cannot occur in the same cycle on one channel.
- Long press, per channel, counter hcnt of width $clog2(HOLD_CYCLES+1):
  - counts while q == 1; cleared while q == 0;
  - when hcnt reaches HOLD_CYCLES-1 with q == 1, btn_long pulses for one cycle and hcnt saturates;
  - no further btn_long until a release and a new press.
- Button held through reset deassertion: reported as a fresh press DEBOUNCE_CYCLES+2 cycles after rst_n rises.
- Reset mid-debounce or mid-hold: counts are discarded; no pulse is generated by the reset itself.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- Defined:
  - after btn_long fires, a per-channel repeat counter runs while q == 1;
  - btn_press re-pulses every REPEAT_CYCLES cycles, the first repeat REPEAT_CYCLES cycles after the btn_long cycle;
  - the counter clears on release or reset;
  - btn_long itself still fires only once per press.
- Not defined: no repeat counter logic is built; btn_press pulses exactly once per accepted press; REPEAT_CYCLES is ignored.

Test Plan (bench params: NUM_BTNS=3, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5, ACTIVE_LOW_IN=0):
- Clean press: btn_raw[0] 0->1 held, first sampled at edge k -> btn_level[0]=1 after edge k+5; btn_press[0] high exactly that one cycle; other channels stay 0.
- Bounce rejection: btn_raw[1] toggles 1,0,1,0 with 3-cycle high runs for 30 cycles -> btn_level[1] never rises, no pulses; then held 1 for 6 cycles -> single btn_press[1].
- Long press: hold btn_raw[2]=1 for 30 cycles -> btn_long[2] one pulse 10 cycles after btn_level[2] rose; release -> btn_release[2] one pulse 5 cycles after the raw fall.
- Simultaneous: all three btn_raw rise on the same edge -> btn_press = 3'b111 for one cycle, identical latency on every channel.
- Reset mid-operation: assert rst_n low 2 cycles after btn_level[0] rose -> all outputs 0 immediately (asynchronous); raw still high at rst_n rise -> new btn_press[0] 6 cycles later; no btn_long from the pre-reset hold.
- Auto-repeat (BUTTON_AUTOREPEAT_EN defined): hold 40 cycles -> btn_press at the accept cycle, then at btn_long+5, +10, +15, ...; macro undefined -> exactly one btn_press.
